flip_event_logger: RTL and testbench

Downstream consumer of the bit-flip sensor tree's `error` output. It detects rising edges of `error`, applies an optional hold-off window to suppress repeated reports from one upset, and keeps a saturating event count. Each accepted event is timestamped against a free-running cycle counter and queued in a small FIFO, which the readout/telemetry path drains through a valid/ready handshake.

---
 rtl/flip_logger_pkg.sv | 9 +
 rtl/flip_event_logger_if.sv | 12 +
 rtl/flip_event_fifo.sv | 36 +++
 rtl/flip_event_logger.sv | 76 +++++++
 tb/tb_flip_event_logger.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/flip_logger_pkg.sv
// flip_logger_pkg: shared FSM states, timestamp type and default parameters for flip_event_logger
package flip_logger_pkg;
  localparam int TS_WIDTH_DEF = 32;
  localparam int COUNT_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int HOLDOFF_DEF = 4;
  typedef enum logic {ARMED, HOLD} state_t;
  typedef logic [TS_WIDTH_DEF-1:0] ts_t;
endpackage

// File: rtl/flip_event_logger_if.sv
// flip_event_logger_if: valid/ready timestamp readout channel
interface flip_event_logger_if
  import flip_logger_pkg::*;
#(
  parameter int TS_WIDTH = TS_WIDTH_DEF
);
  logic                evt_valid;
  logic                evt_ready;
  logic [TS_WIDTH-1:0] evt_timestamp;
  modport master(output evt_valid, evt_timestamp, input evt_ready);
  modport slave(input evt_valid, evt_timestamp, output evt_ready);
endinterface

// File: rtl/flip_event_fifo.sv
// flip_event_fifo: synchronous show-ahead FIFO with flush, pointers one bit wider than the address
module flip_event_fifo #(
  parameter int W = 32,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem_q [D];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = flush ? '0 : wr_q + (AW+1)'(push);
    rd_d = flush ? '0 : rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/flip_event_logger.sv
// flip_event_logger: timestamped error-edge logger with saturating count; hold-off FSM under FLIP_LOGGER_HOLDOFF_EN
module flip_event_logger
  import flip_logger_pkg::*;
#(
  parameter int TS_WIDTH = TS_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   error,
  input  logic                   clear,
  flip_event_logger_if.master    evt,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   overflow,
  output logic                   armed
);
  logic [TS_WIDTH-1:0] ts_q, ts_d, head;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic error_q, ovf_q, ovf_d, rise, accept, push, pop, full, empty;
  assign rise = error & ~error_q;
`ifdef FLIP_LOGGER_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF) + 1;
  state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  always_comb begin
    accept  = state_q == ARMED && rise;
    state_d = state_q == ARMED ? (rise ? HOLD : ARMED) : (hold_q == '0 ? ARMED : HOLD);
    hold_d  = state_q == ARMED ? HW'(HOLDOFF - 1) : hold_q - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMED;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
  assign armed = state_q == ARMED;
`else
  logic unused_holdoff;
  assign unused_holdoff = |HOLDOFF;
  assign accept = rise;
  assign armed  = 1'b1;
`endif
  assign pop  = evt.evt_valid & evt.evt_ready;
  assign push = accept & ~clear & (~full | pop);
  always_comb begin
    ts_d  = ts_q + 1'b1;
    cnt_d = clear ? '0 : cnt_q + COUNT_WIDTH'(accept && !(&cnt_q));
    ovf_d = clear ? 1'b0 : ovf_q | (accept & full & ~pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      error_q <= error;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  flip_event_fifo #(.W(TS_WIDTH), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(clear),
    .din(ts_q), .dout(head), .full(full), .empty(empty)
  );
  assign evt.evt_valid     = ~empty;
  assign evt.evt_timestamp = head;
  assign event_count       = cnt_q;
  assign overflow          = ovf_q;
endmodule

// File: tb/tb_flip_event_logger.sv
// tb_flip_event_logger: scoreboard bench for flip_event_logger
module tb_flip_event_logger;
  localparam int TW = 32, CW = 4, D = 8, HO = 4;
`ifdef FLIP_LOGGER_HOLDOFF_EN
  localparam bit HO_EN = 1'b1;
`else
  localparam bit HO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, error = 1'b0, clear = 1'b0;
  logic [CW-1:0] event_count;
  logic overflow, armed;
  flip_event_logger_if #(.TS_WIDTH(TW)) evt_if ();
  flip_event_logger #(.TS_WIDTH(TW), .COUNT_WIDTH(CW), .FIFO_DEPTH(D), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .error(error), .clear(clear), .evt(evt_if),
    .event_count(event_count), .overflow(overflow), .armed(armed)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] tb_ts;
  logic [CW-1:0] exp_cnt;
  bit exp_ovf, prev_e;
  int holdrem;
  task automatic tick(input bit e, input bit r, input bit c);
    logic [TW-1:0] ts_now;
    bit rise, acc, pop;
    error = e;
    evt_if.evt_ready = r;
    clear = c;
    ts_now = tb_ts;
    rise = e && !prev_e;
    pop = r && exp_q.size() != 0;
    acc = 1'b0;
    if (holdrem > 0) holdrem--;
    else begin
      acc = rise;
      if (rise && HO_EN) holdrem = HO;
    end
    @(posedge clk);
    if (c) begin
      exp_q.delete();
      exp_cnt = '0;
      exp_ovf = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        if (exp_cnt != '1) exp_cnt++;
        if (exp_q.size() < D) exp_q.push_back(ts_now);
        else exp_ovf = 1'b1;
      end
    end
    prev_e = e;
    tb_ts++;
    @(negedge clk);
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    error = 1'b0;
    clear = 1'b0;
    evt_if.evt_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_ts = '0;
    exp_q.delete();
    exp_cnt = '0;
    exp_ovf = 1'b0;
    prev_e = 1'b0;
    holdrem = 0;
  endtask
  task automatic pulse(input bit r);
    tick(1'b1, r, 1'b0);
    for (int i = 0; i <= HO; i++) tick(1'b0, r, 1'b0);
  endtask
  task automatic drain(input string name);
    while (exp_q.size() != 0) begin
      checks++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_timestamp !== exp_q[0]) begin
        errors++;
        $display("FAIL %s drain: valid=%0b ts=%0d expected valid=1 ts=%0d", name, evt_if.evt_valid, evt_if.evt_timestamp, exp_q[0]);
      end
      tick(1'b0, 1'b1, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s empty: valid=%0b expected 0", name, evt_if.evt_valid);
    end
  endtask
  task automatic test_reset();
    reset_dut();
    checks += 5;
    if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %0b expected 0", evt_if.evt_valid); end
    if (evt_if.evt_timestamp !== '0) begin errors++; $display("FAIL reset ts: got %0d expected 0", evt_if.evt_timestamp); end
    if (event_count !== '0) begin errors++; $display("FAIL reset count: got %0d expected 0", event_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %0b expected 0", overflow); end
    if (armed !== 1'b1) begin errors++; $display("FAIL reset armed: got %0b expected 1", armed); end
  endtask
  task automatic test_single();
    while (tb_ts < 10) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    checks += 4;
    if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL single valid: got %0b expected 1", evt_if.evt_valid); end
    if (evt_if.evt_timestamp !== 32'd10) begin errors++; $display("FAIL single ts: got %0d expected 10", evt_if.evt_timestamp); end
    if (event_count !== 4'd1) begin errors++; $display("FAIL single count: got %0d expected 1", event_count); end
    if (armed !== !HO_EN) begin errors++; $display("FAIL single armed: got %0b expected %0b", armed, !HO_EN); end
    tick(1'b0, 1'b0, 1'b0);
    drain("single");
  endtask
  task automatic test_holdoff();
    tick(1'b0, 1'b0, 1'b1);
    while (tb_ts < 20) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (armed !== (holdrem == 0)) begin errors++; $display("FAIL holdoff armed: got %0b expected %0b", armed, holdrem == 0); end
    for (int i = 0; i <= HO; i++) tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (event_count !== (HO_EN ? 4'd1 : 4'd2)) begin errors++; $display("FAIL holdoff count: got %0d expected %0d", event_count, HO_EN ? 1 : 2); end
    drain("holdoff");
  endtask
  task automatic test_overflow();
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) pulse(1'b0);
    checks += 2;
    if (event_count !== 4'd9) begin errors++; $display("FAIL overflow count: got %0d expected 9", event_count); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow flag: got %0b expected 1", overflow); end
    drain("overflow");
  endtask
  task automatic test_full_pop();
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < D; i++) pulse(1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    checks += 2;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop overflow: got %0b expected 0", overflow); end
    if (event_count !== exp_cnt) begin errors++; $display("FAIL full_pop count: got %0d expected %0d", event_count, exp_cnt); end
    drain("full_pop");
  endtask
  task automatic test_clear();
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) pulse(1'b0);
    tick(1'b1, 1'b0, 1'b1);
    checks += 3;
    if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL clear valid: got %0b expected 0", evt_if.evt_valid); end
    if (event_count !== '0) begin errors++; $display("FAIL clear count: got %0d expected 0", event_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL clear overflow: got %0b expected 0", overflow); end
    for (int i = 0; i <= HO; i++) tick(1'b0, 1'b0, 1'b0);
    checks += 2;
    if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL clear late valid: got %0b expected 0", evt_if.evt_valid); end
    if (event_count !== '0) begin errors++; $display("FAIL clear late count: got %0d expected 0", event_count); end
  endtask
  task automatic test_saturate();
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) pulse(1'b1);
    checks += 2;
    if (event_count !== 4'd15) begin errors++; $display("FAIL saturate count: got %0d expected 15", event_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL saturate overflow: got %0b expected 0", overflow); end
    drain("saturate");
  endtask
  task automatic test_back_to_back();
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      checks++;
      if (evt_if.evt_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL b2b valid: got %0b expected %0b", evt_if.evt_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (evt_if.evt_timestamp !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b ts: got %0d expected %0d", evt_if.evt_timestamp, exp_q[0]);
        end
      end
      tick(i % (HO + 1) == 0, 1'($urandom_range(0, 1)), 1'b0);
    end
    checks++;
    if (event_count !== exp_cnt || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL b2b totals: count=%0d ovf=%0b expected count=%0d ovf=%0b", event_count, overflow, exp_cnt, exp_ovf);
    end
    tick(1'b0, 1'b0, 1'b0);
    drain("b2b");
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) pulse(1'b0);
    reset_dut();
    checks += 3;
    if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL midreset valid: got %0b expected 0", evt_if.evt_valid); end
    if (event_count !== '0) begin errors++; $display("FAIL midreset count: got %0d expected 0", event_count); end
    if (evt_if.evt_timestamp !== '0) begin errors++; $display("FAIL midreset ts: got %0d expected 0", evt_if.evt_timestamp); end
    pulse(1'b0);
    drain("midreset");
  endtask
  initial begin
    evt_if.evt_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_holdoff();
    test_overflow();
    test_full_pop();
    test_clear();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
